// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel pipeline
package sobel_pkg;

    localparam int PIX_W         = 8;
    localparam int IMG_W_DEFAULT = 320;
    localparam int IMG_H_DEFAULT = 240;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VSYNC,
        ST_CAPTURE,
        ST_DRAIN,
        ST_PROCESS
    } gray_ctrl_state_t;

endpackage

// File: rtl/gray_frame_ctrl_if.sv
// rtl/gray_frame_ctrl_if.sv - camera pixel input and frame-buffer write bus
// Camera side: cam_vsync_i, cam_valid_i, red_i/green_i/blue_i (no backpressure).
// Buffer side: wr_en_o, wr_addr_o (raster address), wr_data_o (gray value).
// slave = gray_frame_ctrl, master = the camera / frame-buffer environment.
interface gray_frame_ctrl_if #(
    parameter int ADDR_W = 17
) ();
    import sobel_pkg::*;

    logic              cam_vsync_i;
    logic              cam_valid_i;
    logic [PIX_W-1:0]  red_i;
    logic [PIX_W-1:0]  green_i;
    logic [PIX_W-1:0]  blue_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [PIX_W-1:0]  wr_data_o;

    modport master (
        output cam_vsync_i, cam_valid_i, red_i, green_i, blue_i,
        input  wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  cam_vsync_i, cam_valid_i, red_i, green_i, blue_i,
        output wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/rgb_to_grayscale.sv
// rtl/rgb_to_grayscale.sv - one-cycle RGB to gray converter
// Ports: clk, rst (async, active high), cam_done_i (pixel strobe),
//        red_i/green_i/blue_i in; gray_o, gray_valid_o out one cycle later.
// Luma approximation: R/4 + G/2 + B/16 (max 205, never overflows 8 bits).
module rgb_to_grayscale
    import sobel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cam_done_i,
    input  logic [PIX_W-1:0] red_i,
    input  logic [PIX_W-1:0] green_i,
    input  logic [PIX_W-1:0] blue_i,
    output logic [PIX_W-1:0] gray_o,
    output logic             gray_valid_o
);
    logic [PIX_W-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;

    always_comb begin
        gray_d  = gray_q;
        valid_d = cam_done_i;
        if (cam_done_i) begin
            gray_d = {2'b00, red_i[PIX_W-1:2]}
                   + {1'b0, green_i[PIX_W-1:1]}
                   + {4'b0000, blue_i[PIX_W-1:4]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            gray_q  <= gray_d;
            valid_q <= valid_d;
        end
    end

    assign gray_o       = gray_q;
    assign gray_valid_o = valid_q;
endmodule

// File: rtl/gray_frame_ctrl.sv
// rtl/gray_frame_ctrl.sv - frame sequencer for the grayscale stage
// Ports: clk, rst (async, active high); start_i arm, cont_i continuous mode,
//        sobel_done_i buffer release; bus (slave) carries camera pixels in and
//        frame-buffer writes out; sobel_start_o/frame_done_o handoff pulses,
//        busy_o, short_frame_o, frame_cnt_o status.
module gray_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int ADDR_W = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                sobel_done_i,
    gray_frame_ctrl_if.slave    bus,
    output logic                sobel_start_o,
    output logic                frame_done_o,
    output logic                busy_o,
    output logic                short_frame_o,
    output logic [7:0]          frame_cnt_o
);
    gray_ctrl_state_t  state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              handoff_q, handoff_d;
    logic              short_q, short_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              restart;
    logic              accept;
    logic              pix_last;
    logic [ADDR_W-1:0] pix_col, pix_row, pix_idx;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        handoff_d   = 1'b0;
        short_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // vsync restarts the raster in both WAIT_VSYNC and CAPTURE; a pixel
        // arriving with it is pixel 0 of the new frame.
        restart  = bus.cam_vsync_i && (state_q == ST_WAIT_VSYNC || state_q == ST_CAPTURE);
        accept   = bus.cam_valid_i && (state_q == ST_CAPTURE || restart);
        pix_col  = restart ? '0 : col_q;
        pix_row  = restart ? '0 : row_q;
        pix_idx  = pix_row * ADDR_W'(IMG_W) + pix_col;
        pix_last = (pix_col == ADDR_W'(IMG_W - 1)) && (pix_row == ADDR_W'(IMG_H - 1));

        case (state_q)
            ST_IDLE:       if (start_i) state_d = ST_WAIT_VSYNC;
            ST_WAIT_VSYNC: if (bus.cam_vsync_i) state_d = ST_CAPTURE;
            ST_CAPTURE:    if (bus.cam_vsync_i) short_d = 1'b1;
            ST_DRAIN: begin
                state_d     = ST_PROCESS;
                handoff_d   = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            ST_PROCESS:    if (sobel_done_i) state_d = cont_i ? ST_WAIT_VSYNC : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        if (restart) begin
            col_d = '0;
            row_d = '0;
        end

        if (accept) begin
            addr_d = pix_idx;
            if (pix_last) begin
                state_d = ST_DRAIN;
                col_d   = '0;
                row_d   = '0;
            end else if (pix_col == ADDR_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            handoff_q   <= 1'b0;
            short_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            handoff_q   <= handoff_d;
            short_q     <= short_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The converter only sees accepted pixels, so its valid output is the
    // write strobe, aligned with addr_q.
    rgb_to_grayscale u_gray (
        .clk          (clk),
        .rst          (rst),
        .cam_done_i   (accept),
        .red_i        (bus.red_i),
        .green_i      (bus.green_i),
        .blue_i       (bus.blue_i),
        .gray_o       (bus.wr_data_o),
        .gray_valid_o (bus.wr_en_o)
    );

    assign bus.wr_addr_o  = addr_q;
    assign sobel_start_o  = handoff_q;
    assign frame_done_o   = handoff_q;
    assign busy_o         = busy_q;
    assign short_frame_o  = short_q;
    assign frame_cnt_o    = frame_cnt_q;
endmodule

// File: doc/gray_frame_ctrl.md
# gray_frame_ctrl

Frame-level sequencer for the grayscale stage of the Sobel pipeline. It arms on a start request, aligns to camera vsync, gates camera pixels into an internal `rgb_to_grayscale` instance, and writes each gray pixel to the frame buffer at a raster address. When the frame is complete it hands the buffer to the Sobel engine and holds off new frames until Sobel reports done.

## Interface
- `IMG_W`, default 320: pixels per line.
- `IMG_H`, default 240: lines per frame.
- `ADDR_W`, default 17: frame-buffer address width, ≥ clog2(IMG_W*IMG_H).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: arm capture. Level-sampled; honoured only in IDLE.
- `cont_i` in 1: continuous mode. Sampled on leaving PROCESS: 1 goes to WAIT_VSYNC, 0 goes to IDLE.
- `cam_vsync_i` in 1: single-cycle frame-start pulse from the camera.
- `cam_valid_i` in 1: an RGB pixel is present this cycle. No backpressure.
- `red_i`, `green_i`, `blue_i` in 8 each: pixel components.
- `sobel_done_i` in 1: Sobel has finished with the buffer. Pulse.
- `wr_en_o` out 1: frame-buffer write strobe.
- `wr_addr_o` out ADDR_W: raster address, row*IMG_W+col.
- `wr_data_o` out 8: gray value.
- `sobel_start_o` out 1: one-cycle pulse; the buffer is handed to Sobel.
- `frame_done_o` out 1: one-cycle pulse, coincident with `sobel_start_o`.
- `busy_o` out 1: high in every state except IDLE.
- `short_frame_o` out 1: one-cycle pulse when vsync arrives mid-frame.
- `frame_cnt_o` out 8: completed frames, wraps 255→0.

## Operation
- States: IDLE, WAIT_VSYNC, CAPTURE, DRAIN, PROCESS.
- **IDLE:** `start_i`=1 goes to WAIT_VSYNC.
- **WAIT_VSYNC:**
  - `cam_vsync_i` clears the pixel counter and goes to CAPTURE.
  - A `cam_valid_i` in the same cycle as vsync is pixel 0 of the new frame.
  - `cam_valid_i` without vsync is ignored.
- **CAPTURE:**
  - Each `cam_valid_i` feeds the converter with `cam_done_i` = `cam_valid_i`.
  - The pixel index is pushed into a 1-deep address register, aligned with the converter's one-cycle latency.
  - The index counter increments; col/row counters wrap col at IMG_W.
  - On acceptance of index IMG_W*IMG_H-1, go to DRAIN.
  - `cam_vsync_i` in CAPTURE before the last pixel:
    - pulse `short_frame_o`;
    - reset the counters to 0;
    - stay in CAPTURE;
    - a same-cycle valid is pixel 0.
  - Previously written data is not erased.
- **DRAIN:** one cycle; the last write retires. Go to PROCESS, pulsing `sobel_start_o` and `frame_done_o`, and incrementing `frame_cnt_o` on that transition.
- **PROCESS:**
  - Camera input is ignored; the converter is gated with `cam_done_i`=0, and vsync is ignored.
  - `sobel_done_i` goes to WAIT_VSYNC if `cont_i`, else IDLE.
- `sobel_done_i` outside PROCESS is ignored. `start_i` outside IDLE is ignored.
- Pixels beyond the frame cannot occur, because CAPTURE exits on the last index. Extra valids in DRAIN or PROCESS are dropped.
- **Reset:** asynchronous reset at any time returns to IDLE and zeros all outputs and counters. An in-flight write is discarded (`wr_en_o`=0).

## Timing
- Reset values: `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `sobel_start_o`=0, `frame_done_o`=0, `busy_o`=0, `short_frame_o`=0, `frame_cnt_o`=0.
- A pixel accepted in cycle t gives `wr_en_o`=1 in t+1, with `wr_addr_o` = its index and `wr_data_o` = converter output.
- The last pixel accepted in t gives its write in t+1 (DRAIN), and `sobel_start_o`/`frame_done_o` in t+2.
- `busy_o` is registered from the state: it rises the cycle after `start_i` is sampled.
- `short_frame_o` is asserted the cycle after the offending vsync.
- Back-to-back valids give back-to-back writes, at full throughput.

## Structure
- Shared package `sobel_pkg`:
  - state enum `gray_ctrl_state_t`;
  - default `IMG_W`/`IMG_H` constants;
  - `PIX_W`=8.
- One sub-module: the existing `rgb_to_grayscale`, instantiated unchanged.
- The FSM, counters and address pipeline register live in `gray_frame_ctrl`.

## Test plan
All scenarios use IMG_W=4, IMG_H=2.

- **Reset/idle:** reset, then 5 idle cycles → all outputs 0, `busy_o`=0; valids are ignored with no `wr_en_o`.
- **Single frame:**
  - Stimulus: `start_i`, vsync, then 8 consecutive valids of r=4, g=2, b=16.
  - Writes: 8 writes with addresses 0..7, data 3 each, each one cycle after its pixel.
  - Handoff: `sobel_start_o` 2 cycles after the 8th pixel; `frame_cnt_o`=1.
- **Gapped input:** valids on alternate cycles → writes at addresses 0..7 with matching gaps; the address tracks the pixel, not the cycle.
- **Short frame:**
  - Stimulus: 5 pixels, then vsync with a same-cycle valid.
  - Response: `short_frame_o` pulse; next write at address 0; 7 more pixels complete the frame normally.
- **Hold-off:**
  - Stimulus: in PROCESS, vsync plus 8 valids.
  - Response: no writes. `sobel_done_i` with `cont_i`=1 goes to WAIT_VSYNC; the next frame writes from address 0 and `frame_cnt_o`=2.
- **Mid-frame reset:** assert `rst` after 3 pixels → next cycle all outputs 0 and IDLE; a new `start_i` and frame begin at address 0 with `frame_cnt_o`=0.
